// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU/ImmSrc/ResultSrc encodings and stage-control struct for pipe_control_unit
package ctrl_pkg;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic       alu_src;
      logic [3:0] alu_ctrl;
      logic [2:0] funct3;
   } ctrl_t;
   // alt selects sub for funct3=000 and sra for funct3=101
   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
             f3 == 3'b001 ? ALU_SLL :
             f3 == 3'b010 ? ALU_SLT :
             f3 == 3'b011 ? ALU_SLTU :
             f3 == 3'b100 ? ALU_XOR :
             f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
             f3 == 3'b110 ? ALU_OR : ALU_AND;
   endfunction
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational D-stage decode; CTRL_BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu
import ctrl_pkg::*;
module ctrl_decoder (
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output ctrl_t      ctrl,
   output logic [2:0] imm_src,
   output logic       illegal
);
   logic br_ok;
`ifdef CTRL_BRANCH_EXT_EN
   assign br_ok = funct3[2:1] != 2'b01;
`else
   assign br_ok = funct3 == 3'b000;
`endif
   always_comb begin
      ctrl = '0;
      imm_src = IMM_I;
      illegal = 1'b0;
      ctrl.funct3 = funct3;
      case (op)
         OP_LW: begin
            ctrl.reg_write = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.alu_src = 1'b1;
            illegal = funct3 != 3'b010;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src = 1'b1;
            imm_src = IMM_S;
            illegal = funct3 != 3'b010;
         end
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl = alu_op(funct3, funct7b5);
         end
         OP_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src = 1'b1;
            ctrl.alu_ctrl = alu_op(funct3, funct7b5 & (funct3 == 3'b101));
         end
         OP_BR: begin
            ctrl.branch = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
            imm_src = IMM_B;
            illegal = ~br_ok;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.jump = 1'b1;
            imm_src = IMM_J;
         end
         OP_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.jump = 1'b1;
            ctrl.jalr = 1'b1;
            ctrl.alu_src = 1'b1;
            illegal = funct3 != 3'b000;
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.result_src = RES_IMM;
            ctrl.alu_src = 1'b1;
            imm_src = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         ctrl = '0;
         imm_src = IMM_I;
      end
   end
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: D/E/M/W control pipeline and PCSrcE; CTRL_BRANCH_EXT_EN widens legal branches in ctrl_decoder
import ctrl_pkg::*;
module pipe_control_unit #(
   parameter int ALUCTRL_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 FlushE,
   input  logic                 ZeroE,
   input  logic                 LtE,
   input  logic                 LtuE,
   output logic [2:0]           ImmSrcD,
   output logic                 IllegalD,
   output logic [ALUCTRL_W-1:0] ALUControlE,
   output logic                 ALUSrcE,
   output logic                 JalrE,
   output logic                 ResultSrcE0,
   output logic                 PCSrcE,
   output logic                 MemWriteM,
   output logic                 RegWriteM,
   output logic                 RegWriteW,
   output logic [1:0]           ResultSrcW
);
   ctrl_t ctrl_d, e;
   logic [1:0] result_src_m;
   logic taken;
   ctrl_decoder u_dec (
      .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .ctrl(ctrl_d), .imm_src(ImmSrcD), .illegal(IllegalD)
   );
   always_ff @(posedge clk) begin
      e <= (reset | FlushE) ? '0 : ctrl_d;
      RegWriteM <= reset ? 1'b0 : e.reg_write;
      MemWriteM <= reset ? 1'b0 : e.mem_write;
      result_src_m <= reset ? 2'b00 : e.result_src;
      RegWriteW <= reset ? 1'b0 : RegWriteM;
      ResultSrcW <= reset ? 2'b00 : result_src_m;
   end
   // Only legal branch funct3 values reach E, so one table serves both builds
   assign taken = e.funct3[2:1] == 2'b00 ? ZeroE ^ e.funct3[0] :
                  e.funct3[1] ? LtuE ^ e.funct3[0] : LtE ^ e.funct3[0];
   assign PCSrcE = e.jump | (e.branch & taken);
   assign ALUControlE = ALUCTRL_W'(e.alu_ctrl);
   assign ALUSrcE = e.alu_src;
   assign JalrE = e.jalr;
   assign ResultSrcE0 = e.result_src[0];
endmodule
